ex_timer_ctrl: RTL
==================

# ex_timer_ctrl

Programmable period-timer controller for the 8 MHz `safe_clk` domain. It sequences a period counter and owns its period register and run/stop/one-shot state. A config handshake loads the period and mode; start/stop controls run it. It emits a one-cycle terminal `tick` and a symmetric `wave`, replacing the fixed 1 s counter with a controllable one.

## Interface
- `PERIOD_W`, 24: counter and period width in bits; covers the 8_000_000 default.
- `DEFAULT_PERIOD`, 8_000_000: reset value of the period register, 1 s at 8 MHz.
- `safe_clk` in 1: 8 MHz clock; all logic is on its rising edge.
- `safe_reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: config offer.
- `cfg_ready` out 1: config acceptance; high exactly when the state is IDLE.
- `cfg_period` in `PERIOD_W`: new period P in cycles; sampled on handshake.
- `cfg_oneshot` in 1: mode bit; 1 = one-shot, 0 = periodic; sampled on handshake.
- `start` in 1: level-sampled run request.
- `stop` in 1: level-sampled abort request.
- `pause` in 1: hold request; present only with `EX_TIMER_CTRL_PAUSE_EN`.
- `busy` out 1: high in RUN (and PAUSED).
- `tick` out 1: registered one-cycle pulse at the end of each period.
- `wave` out 1: `busy && (cnt >= (P >> 1))`; derived from registers only.

## Operation
- Registers:
  - `P` holds the period; it resets to `DEFAULT_PERIOD`.
  - `oneshot` holds the mode; it resets to 0.
  - `cnt` is `PERIOD_W` bits wide; it resets to 0.
  - `state` resets to IDLE.
- Handshake:
  - A config is accepted on an edge where `cfg_valid && cfg_ready`.
  - A `cfg_period` below 2 is clamped to 2.
  - Offers made outside IDLE are held off; `cfg_ready` stays 0, nothing is dropped or queued.
- States:
  - IDLE: `cnt` = 0, `busy` = 0. `start` with no `stop` moves to RUN; `cnt` = 0 on entry.
  - RUN: `cnt` increments each cycle.
    - When `cnt == P-1`, next edge sets `cnt` = 0 and `tick` = 1.
    - Periodic mode stays in RUN.
    - One-shot mode goes to IDLE on that same edge.
  - `stop` in RUN goes to IDLE with `cnt` = 0 and no tick.
- Priority and simultaneous events:
  - `stop` beats `start`.
  - `stop` beats the terminal count; the tick is suppressed.
  - `start` while in RUN is ignored; there is no restart.
  - Config and `start` on the same IDLE edge both take effect; RUN uses the new P and mode.
- Arithmetic:
  - `cnt` never exceeds P-1.
  - Compare is unsigned; `P >> 1` floors.
  - With P = 8_000_000, `wave` is high for 4_000_000 cycles and low for 4_000_000 cycles.

## Timing
- `start` sampled at edge k gives `busy` = 1 after edge k.
- The first `tick` is high in the cycle after edge k+P; later ticks follow every P cycles.
- `tick` is never high for two consecutive cycles, since P ≥ 2.
- One-shot: `busy` falls at edge k+P, the same edge that raises `tick`.
- `stop` at edge s: IDLE, `busy` = 0 and `cnt` = 0 after edge s.
- `cfg_ready` is combinational from `state`; it is 1 during and after reset.
- Reset mid-operation forces the reset values immediately, without waiting for a clock edge:
  - IDLE state, `cnt` = 0.
  - `P` = `DEFAULT_PERIOD`, `oneshot` = 0.
  - `tick` = 0, `busy` = 0, `wave` = 0.

## Configuration
- The macro is `EX_TIMER_CTRL_PAUSE_EN`.
- When defined:
  - The `pause` port and a PAUSED state exist.
  - RUN with `pause` high enters PAUSED; `cnt` holds, `wave` holds, `busy` stays 1, no tick.
  - Deasserting `pause` returns to RUN and counting resumes from the held `cnt`.
  - `stop` beats `pause`, from either state; it goes to IDLE.
  - A terminal count coincident with `pause` rising is deferred until resume.
- When undefined: no `pause` port and no PAUSED state.

## Structure
- Package `ex_timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSED);
  - `PERIOD_W` default, `DEFAULT_PERIOD`;
  - `P_MIN` = 2.
- Sub-module `ex_timer_core`: counter datapath (`cnt`, terminal-count detect, `wave` compare), with an enable/clear interface.
- `ex_timer_ctrl` itself holds the FSM, the handshake and the config registers.

## Test plan
All scenarios use `DEFAULT_PERIOD` = 10 unless stated.
- Reset, then `start` for one cycle → ticks 10 cycles after the start edge, then every 10 cycles; `wave` is low for 5 cycles, high for 5 cycles.
- Handshake `cfg_period` = 4 with `cfg_oneshot` = 1 in IDLE, then `start` → exactly one tick 4 cycles later; `busy` falls on that edge; no further ticks.
- `cfg_valid` held high during RUN → `cfg_ready` = 0 throughout; the config is accepted on the first IDLE edge after `stop`.
- `stop` asserted on the terminal-count cycle → no tick, IDLE, `cnt` = 0. `start` together with `stop` in IDLE → stays IDLE.
- `cfg_period` = 0 → clamps to 2; the tick period is 2 and `wave` alternates every cycle.
- With `EX_TIMER_CTRL_PAUSE_EN`, P = 10: `pause` for 7 cycles starting at `cnt` = 3 → tick arrives 17 cycles after start. Asynchronous `safe_reset` pulse mid-RUN → all outputs 0 immediately and P = 10.

Source files
------------

// File: rtl/ex_timer_pkg.sv
// Shared types and constants for the ex_timer_ctrl period timer.
package ex_timer_pkg;

  localparam int DEF_PERIOD_W = 24;
  localparam int DEF_PERIOD   = 8_000_000;
  localparam int P_MIN        = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/ex_timer_ctrl_if.sv
// Config handshake, run controls and timer outputs of ex_timer_ctrl.
// The pause signal exists only when EX_TIMER_CTRL_PAUSE_EN is defined.
interface ex_timer_ctrl_if #(
  parameter int PERIOD_W = 24
);

  // cfg_valid/cfg_ready: a config transfers on a rising edge where both are
  // high; cfg_ready is high only in IDLE, so offers elsewhere simply wait.
  logic                cfg_valid;
  logic                cfg_ready;
  logic [PERIOD_W-1:0] cfg_period;
  logic                cfg_oneshot;
  logic                start;
  logic                stop;
`ifdef EX_TIMER_CTRL_PAUSE_EN
  logic                pause;
`endif
  logic                busy;
  logic                tick;
  logic                wave;

`ifdef EX_TIMER_CTRL_PAUSE_EN
  modport master (
    output cfg_valid, cfg_period, cfg_oneshot, start, stop, pause,
    input  cfg_ready, busy, tick, wave
  );
  modport slave (
    input  cfg_valid, cfg_period, cfg_oneshot, start, stop, pause,
    output cfg_ready, busy, tick, wave
  );
`else
  modport master (
    output cfg_valid, cfg_period, cfg_oneshot, start, stop,
    input  cfg_ready, busy, tick, wave
  );
  modport slave (
    input  cfg_valid, cfg_period, cfg_oneshot, start, stop,
    output cfg_ready, busy, tick, wave
  );
`endif

endinterface

// File: rtl/ex_timer_core.sv
// Period counter datapath: wrapping count, terminal-count detect and the
// half-period compare used to build the symmetric wave.
module ex_timer_core #(
  parameter int PERIOD_W = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [PERIOD_W-1:0] i_period,
  output logic [PERIOD_W-1:0] o_cnt,
  output logic                o_tc,
  output logic                o_wave_ge
);

  logic [PERIOD_W-1:0] r_cnt;

  assign o_cnt     = r_cnt;
  assign o_tc      = (r_cnt == (i_period - PERIOD_W'(1)));
  assign o_wave_ge = (r_cnt >= (i_period >> 1));

  // Clear wins over enable so a stop never lets the count advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : (r_cnt + PERIOD_W'(1));
    end
  end

endmodule

// File: rtl/ex_timer_ctrl.sv
// Programmable period timer: config registers, handshake and run/stop FSM
// around ex_timer_core. Optional pause support: EX_TIMER_CTRL_PAUSE_EN.
module ex_timer_ctrl
  import ex_timer_pkg::*;
#(
  parameter int PERIOD_W       = DEF_PERIOD_W,
  parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
  input  logic                safe_clk,
  input  logic                safe_reset,
  ex_timer_ctrl_if.slave      ctl,
  output timer_state_t        o_dbg_state,
  output logic [PERIOD_W-1:0] o_dbg_cnt,
  output logic [PERIOD_W-1:0] o_dbg_period
);

  timer_state_t        r_state;
  logic [PERIOD_W-1:0] r_period;
  logic                r_oneshot;
  logic                r_tick;
  logic                r_busy;

  logic                w_cfg_fire;
  logic [PERIOD_W-1:0] w_cfg_period;
  logic                w_active;
  logic                w_cnt_en;
  logic                w_cnt_clr;
  logic [PERIOD_W-1:0] w_cnt;
  logic                w_tc;
  logic                w_wave_ge;

  assign ctl.cfg_ready = (r_state == IDLE);
  assign w_cfg_fire    = ctl.cfg_valid && ctl.cfg_ready;
  assign w_cfg_period  = (ctl.cfg_period < PERIOD_W'(P_MIN)) ? PERIOD_W'(P_MIN)
                                                             : ctl.cfg_period;

`ifdef EX_TIMER_CTRL_PAUSE_EN
  assign w_active = (r_state == RUN) || (r_state == PAUSED);
  // Counting resumes on the very edge that leaves PAUSED, so a pause of N
  // sampled cycles delays the tick by exactly N.
  assign w_cnt_en = w_active && !ctl.stop && !ctl.pause;
`else
  assign w_active = (r_state == RUN);
  assign w_cnt_en = w_active && !ctl.stop;
`endif
  assign w_cnt_clr = !w_active || ctl.stop;

  ex_timer_core #(
    .PERIOD_W (PERIOD_W)
  ) u_core (
    .i_clk     (safe_clk),
    .i_rst     (safe_reset),
    .i_en      (w_cnt_en),
    .i_clr     (w_cnt_clr),
    .i_period  (r_period),
    .o_cnt     (w_cnt),
    .o_tc      (w_tc),
    .o_wave_ge (w_wave_ge)
  );

  always_ff @(posedge safe_clk or posedge safe_reset) begin
    if (safe_reset) begin
      r_state   <= IDLE;
      r_period  <= PERIOD_W'(DEFAULT_PERIOD);
      r_oneshot <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cfg_fire) begin
            r_period  <= w_cfg_period;
            r_oneshot <= ctl.cfg_oneshot;
          end
          if (ctl.start && !ctl.stop) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
`ifdef EX_TIMER_CTRL_PAUSE_EN
        RUN, PAUSED: begin
`else
        RUN: begin
`endif
          if (ctl.stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
`ifdef EX_TIMER_CTRL_PAUSE_EN
          end else if (ctl.pause) begin
            r_state <= PAUSED;
`endif
          end else begin
            r_state <= RUN;
            if (w_tc) begin
              r_tick <= 1'b1;
              if (r_oneshot) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.busy = r_busy;
  assign ctl.tick = r_tick;
  assign ctl.wave = r_busy && w_wave_ge;

  assign o_dbg_state  = r_state;
  assign o_dbg_cnt    = w_cnt;
  assign o_dbg_period = r_period;

endmodule
